// File: rtl/divisor_ctrl.sv
// Programmable clock-enable generator: 1-cycle tick every div_reg cycles plus a square wave toggling per tick.
// Config is taken only in IDLE (cfg_ready low otherwise); the first tick appears N cycles after the start edge.
module divisor_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 8,
  parameter int BURST_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               cfg_mode,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               slow_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  state_t             state;
  logic [CNT_W-1:0]   div_reg;
  logic               mode_reg;
  logic [BURST_W-1:0] count_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] remaining;

  logic               cfg_load;
  logic               eff_mode;
  logic [BURST_W-1:0] eff_count;
  logic               tick_due;

  assign cfg_ready = (state == IDLE);
  assign cfg_load  = cfg_valid && cfg_ready && (cfg_div != '0);
  // A start on the same edge as an accepted config must see the new values.
  assign eff_mode  = cfg_load ? cfg_mode  : mode_reg;
  assign eff_count = cfg_load ? cfg_count : count_reg;
  assign tick_due  = (cnt == div_reg - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_reg   <= CNT_W'(DEFAULT_DIV);
      mode_reg  <= 1'b0;
      count_reg <= '0;
      cnt       <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      slow_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid && (cfg_div == '0)) begin
            err <= 1'b1;
          end else if (cfg_load) begin
            div_reg   <= cfg_div;
            mode_reg  <= cfg_mode;
            count_reg <= cfg_count;
          end
          if (start && !stop) begin
            cnt <= '0;
            if (!eff_mode) begin
              state <= RUN;
              busy  <= 1'b1;
            end else if (eff_count != '0) begin
              state     <= BURST;
              remaining <= eff_count;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN, BURST: begin
          if (stop) begin
            state     <= IDLE;
            cnt       <= '0;
            slow_out  <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (tick_due) begin
            cnt      <= '0;
            tick     <= 1'b1;
            slow_out <= ~slow_out;
            if (state == BURST && remaining != '0) begin
              remaining <= remaining - BURST_W'(1);
              if (remaining == BURST_W'(1)) begin
                done  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
